// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer handshakes and the FIFO write port that
// fifo_wr_arbiter sits between.
//
// Signals
//   req_vld          N_REQ     producer i has a beat offered
//   req_data         N_REQ*DW  producer i data at [i*DW +: DW]
//   req_rdy          N_REQ     beat from producer i accepted this cycle
//   fifo_full        1         FIFO full flag
//   fifo_write_en    1         write strobe to the FIFO
//   fifo_write_data  DW        data to the FIFO
//   gnt_oh           N_REQ     one-hot current grant, 0 when idle
//   busy             1         arbiter is holding a grant
//   wr_cnt           N_REQ*8   per-producer accepted-beat counters
//                              (present only with FIFO_ARB_STATS_EN)
//
// Modports
//   master : producers + FIFO side, drives requests and the full flag
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int DW    = 4
);

    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_rdy;
    logic                fifo_full;
    logic                fifo_write_en;
    logic [DW-1:0]       fifo_write_data;
    logic [N_REQ-1:0]    gnt_oh;
    logic                busy;

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*8-1:0]  wr_cnt;

    modport master (
        output req_vld,
        output req_data,
        output fifo_full,
        input  req_rdy,
        input  fifo_write_en,
        input  fifo_write_data,
        input  gnt_oh,
        input  busy,
        input  wr_cnt
    );

    modport slave (
        input  req_vld,
        input  req_data,
        input  fifo_full,
        output req_rdy,
        output fifo_write_en,
        output fifo_write_data,
        output gnt_oh,
        output busy,
        output wr_cnt
    );
`else
    modport master (
        output req_vld,
        output req_data,
        output fifo_full,
        input  req_rdy,
        input  fifo_write_en,
        input  fifo_write_data,
        input  gnt_oh,
        input  busy
    );

    modport slave (
        input  req_vld,
        input  req_data,
        input  fifo_full,
        output req_rdy,
        output fifo_write_en,
        output fifo_write_data,
        output gnt_oh,
        output busy
    );
`endif

endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A producer holds a grant for a burst of up to MAX_BURST accepted beats;
// the grant ends early if the producer withdraws its valid. Writes are
// never issued while the FIFO reports full.
//
// Parameters
//   N_REQ      number of producers (>= 2)
//   DW         data width
//   MAX_BURST  max accepted beats per grant (>= 1)
//
// Ports
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   fifo_wr_arbiter_if.slave: producer handshakes, FIFO write
//         port, grant/busy status
//
// Optional feature
//   FIFO_ARB_STATS_EN : when defined, adds saturating 8-bit per-producer
//   counters of accepted beats, presented on bus.wr_cnt.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ     = 3,
    parameter int DW        = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     lastGnt_q;
    logic [IW-1:0]     lastGnt_d;
    logic [CW-1:0]     beatCnt_q;
    logic [CW-1:0]     beatCnt_d;

    logic [IW-1:0]     winner;
    logic              winnerFound;
    int                candidate;
    logic [N_REQ-1:0]  gntVec;
    logic              accept;
    logic [N_REQ-1:0]  reqRdy;
    logic              writeEn;
    logic [DW-1:0]     writeData;
    logic [N_REQ-1:0]  gntOh;
    logic              busyFlag;

    // While a grant is held, lastGnt_q is the granted producer (it is loaded
    // with the winner on the grant edge), so a single register serves as both
    // the round-robin pointer and the current grant index.
    always_comb begin
        gntVec = '0;
        gntVec[lastGnt_q] = 1'b1;
    end

    // Round-robin search: scan producers starting just after the last winner,
    // wrapping modulo N_REQ, so the most recent winner is considered last.
    // This is what keeps a producer from winning twice in a row while any
    // other producer is requesting.
    always_comb begin
        winnerFound = 1'b0;
        winner      = '0;
        candidate   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            candidate = int'(lastGnt_q) + k;
            if (candidate >= N_REQ) begin
                candidate = candidate - N_REQ;
            end
            if (!winnerFound && bus.req_vld[candidate[IW-1:0]]) begin
                winnerFound = 1'b1;
                winner      = candidate[IW-1:0];
            end
        end
    end

    // Next-state and output logic. A beat is accepted only in GRANT, only from
    // the granted producer, and only while the FIFO has room; the handshake
    // is combinational so the producer sees req_rdy in the same cycle its data
    // is written. A stall (valid but full) holds the beat counter; a withdrawn
    // valid ends the burst without a write.
    always_comb begin
        state_d   = state_q;
        lastGnt_d = lastGnt_q;
        beatCnt_d = beatCnt_q;
        accept    = 1'b0;
        reqRdy    = '0;
        writeEn   = 1'b0;
        writeData = '0;
        gntOh     = '0;
        busyFlag  = 1'b0;

        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d   = GRANT;
                    lastGnt_d = winner;
                    beatCnt_d = '0;
                end
            end

            GRANT: begin
                busyFlag = 1'b1;
                gntOh    = gntVec;
                accept   = bus.req_vld[lastGnt_q] & ~bus.fifo_full;
                if (accept) begin
                    reqRdy    = gntVec;
                    writeEn   = 1'b1;
                    writeData = bus.req_data[int'(lastGnt_q)*DW +: DW];
                    if (beatCnt_q == CW'(MAX_BURST - 1)) begin
                        state_d   = IDLE;
                        beatCnt_d = '0;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end else if (!bus.req_vld[lastGnt_q]) begin
                    state_d   = IDLE;
                    beatCnt_d = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                beatCnt_d = '0;
            end
        endcase
    end

    // State register. Reset points the round-robin pointer at the last
    // producer so that producer 0 is the first one searched after reset.
    // Because every output is decoded from state_q, asserting rst drops the
    // grant and any in-flight write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lastGnt_q <= IW'(N_REQ - 1);
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lastGnt_q <= lastGnt_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign bus.req_rdy         = reqRdy;
    assign bus.fifo_write_en   = writeEn;
    assign bus.fifo_write_data = writeData;
    assign bus.gnt_oh          = gntOh;
    assign bus.busy            = busyFlag;

`ifdef FIFO_ARB_STATS_EN
    logic [7:0] wrCnt_q [N_REQ];

    // Per-producer accepted-beat counters. They stop at 255 rather than
    // wrapping so a long-running producer never appears to have written less.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                wrCnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (reqRdy[i] && (wrCnt_q[i] != 8'hFF)) begin
                    wrCnt_q[i] <= wrCnt_q[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : gen_wr_cnt
        assign bus.wr_cnt[g*8 +: 8] = wrCnt_q[g];
    end
`endif

endmodule
